// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared states, byte counts and defaults for the instruction loader
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_FIN   = 3'd5
    } loader_state_e;

    localparam int LEN_BYTES         = 2;
    localparam int WORD_BYTES        = 4;
    localparam int CHK_BYTES         = 4;
    localparam int DEFAULT_ADDR_W    = 10;
    localparam int DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and instruction RAM write port out
interface instr_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// rtl/instr_loader_word_assembler.sv - 8 to 32 bit little-endian word assembler
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    // Only the first three bytes are stored; the fourth is taken straight
    // from the input so the full word is ready in the accepting cycle.
    logic [23:0] shreg;
    logic [1:0]  idx;

    // Shift bytes in from the top so byte 0 ends up in bits 7:0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= 24'd0;
            idx   <= 2'd0;
        end else if (clr) begin
            shreg <= 24'd0;
            idx   <= 2'd0;
        end else if (in_valid) begin
            shreg <= {in_data, shreg[23:8]};
            idx   <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
        end
    end

    assign word       = {in_data, shreg};
    assign word_valid = in_valid && (idx == LAST_IDX);

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time instruction RAM writer; LOADER_CHECKSUM_EN adds a sum trailer check
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_loader_if.master      bus,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_cnt
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LEN   = ST_LEN;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_WRITE = ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = ST_CHK;
`endif
    localparam logic [2:0] S_FIN   = ST_FIN;

    localparam logic LEN_LAST = 1'(LEN_BYTES - 1);

    logic [2:0]        state;
    logic [7:0]        len_lo;
    logic              len_idx;
    logic [15:0]       len_n;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_din_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum;
`endif

    logic              accept;
    logic              asm_clr;
    logic              asm_in;
    logic [31:0]       asm_word;
    logic              asm_word_valid;
    logic [15:0]       len_word;
    logic              len_bad;
    logic [ADDR_W:0]   cnt_next;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    assign bus.rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign asm_in       = accept && ((state == S_DATA) || (state == S_CHK));
`else
    assign bus.rx_ready = (state == S_LEN) || (state == S_DATA);
    assign asm_in       = accept && (state == S_DATA);
`endif

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign asm_clr   = start && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign cpu_hold  = busy;

    assign len_word  = {bus.rx_data, len_lo};
    assign len_bad   = (len_word == 16'd0) || (32'(len_word) > 32'(MAX_WORDS));
    assign cnt_next  = word_cnt + 1'b1;
    assign last_word = (16'(cnt_next) == len_n);

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (asm_clr),
        .in_valid   (asm_in),
        .in_data    (bus.rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // Load sequencing: length header, word assembly, RAM write, optional trailer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_lo     <= 8'd0;
            len_idx    <= 1'b0;
            len_n      <= 16'd0;
            word_cnt   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 32'd0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEN;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
                        len_idx  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= 32'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_idx == LEN_LAST) begin
                            len_n <= len_word;
                            if (len_bad) begin
                                err   <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            len_lo  <= bus.rx_data;
                            len_idx <= len_idx + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (asm_word_valid) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= word_cnt[ADDR_W-1:0];
                        mem_din_q  <= asm_word;
                        state      <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= sum + asm_word;
`endif
                    end
                end
                S_WRITE: begin
                    word_cnt <= cnt_next;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_FIN;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (asm_word_valid) begin
                        if (asm_word != sum) begin
                            err <= 1'b1;
                        end
                        state <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    if (!err) begin
                        done <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    localparam int ADDR_W = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy;
    logic            cpu_hold;
    logic            done;
    logic            err;
    logic [ADDR_W:0] word_cnt;

    instr_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (ifc),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]       img     [0:1023];
    logic [ADDR_W-1:0] wr_addr [0:1023];
    logic [31:0]       wr_data [0:1023];
    int                wr_n = 0;
    int                ready_in_write = 0;

    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            if (wr_n < 1024) begin
                wr_addr[wr_n] = ifc.mem_addr;
                wr_data[wr_n] = ifc.mem_din;
            end
            wr_n = wr_n + 1;
            if (ifc.rx_ready !== 1'b0) ready_in_write = ready_in_write + 1;
        end
    end

    task automatic clear_log();
        wr_n = 0;
        ready_in_write = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        while (ifc.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: rx_ready low for %0d cycles, required high", n);
        end
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic gap(input int g);
        if (g > 0) repeat ($urandom_range(0, g)) @(negedge clk);
    endtask

    task automatic send_len(input logic [15:0] n, input int g);
        gap(g);
        send_byte(n[7:0]);
        gap(g);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int g);
        for (int i = 0; i < 4; i++) begin
            gap(g);
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic send_body(input int n, input int g, input logic [31:0] adj);
        logic [31:0] s;
        s = adj;
        for (int k = 0; k < n; k++) begin
            send_word(img[k], g);
            s = s + img[k];
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(s, g);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy, cpu_hold, ifc.rx_ready, ifc.mem_we, done, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 000000", {busy, cpu_hold, ifc.rx_ready, ifc.mem_we, done, err});
        end
        vectors++;
        if (word_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_word_cnt: got %0d required 0", word_cnt);
        end
        vectors++;
        if (ifc.mem_addr !== '0 || ifc.mem_din !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got addr %h din %h required 0 0", ifc.mem_addr, ifc.mem_din);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || ifc.rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy %b rx_ready %b required 0 0", busy, ifc.rx_ready);
        end
    endtask

    task automatic test_basic();
        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
        clear_log();
        start        = 1'b1;
        ifc.rx_data  = 8'h02;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || ifc.rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_rise: got busy %b hold %b ready %b required 1 1 1", busy, cpu_hold, ifc.rx_ready);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(img[0], 0);
        vectors++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 10'd0 || ifc.mem_din !== 32'h12345678 || ifc.rx_ready !== 1'b0 || word_cnt !== 11'd0) begin
            miscompares++;
            $display("FAIL basic_write_latency: got we %b addr %h din %h ready %b cnt %0d required 1 000 12345678 0 0",
                     ifc.mem_we, ifc.mem_addr, ifc.mem_din, ifc.rx_ready, word_cnt);
        end
        send_word(img[1], 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(img[0] + img[1], 0);
`endif
        wait_idle("basic");
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 11'd2) begin
            miscompares++;
            $display("FAIL basic_status: got done %b err %b cnt %0d required 1 0 2", done, err, word_cnt);
        end
        vectors++;
        if (wr_n !== 2) begin
            miscompares++;
            $display("FAIL basic_we_count: got %0d required 2", wr_n);
        end
        vectors++;
        if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678 || wr_addr[1] !== 10'd1 || wr_data[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_writes: got %h=%h %h=%h required 000=12345678 001=deadbeef",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        vectors++;
        if (ifc.mem_we !== 1'b0 || ifc.mem_addr !== 10'd1 || ifc.mem_din !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_hold: got we %b addr %h din %h required 0 001 deadbeef", ifc.mem_we, ifc.mem_addr, ifc.mem_din);
        end
    endtask

    task automatic test_gaps();
        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
        clear_log();
        pulse_start();
        send_len(16'd2, 4);
        send_body(2, 4, 32'd0);
        wait_idle("gaps");
        vectors++;
        if (wr_n !== 2 || wr_data[0] !== 32'h12345678 || wr_data[1] !== 32'hDEADBEEF || wr_addr[1] !== 10'd1) begin
            miscompares++;
            $display("FAIL gaps_writes: got n %0d %h %h required 2 12345678 deadbeef", wr_n, wr_data[0], wr_data[1]);
        end
        vectors++;
        if (ready_in_write !== 0) begin
            miscompares++;
            $display("FAIL gaps_ready_in_write: got %0d cycles required 0", ready_in_write);
        end
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_status: got done %b err %b required 1 0", done, err);
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens [0:1];
        lens[0] = 16'h0000;
        lens[1] = 16'h0401;
        for (int i = 0; i < 2; i++) begin
            clear_log();
            pulse_start();
            send_len(lens[i], 0);
            wait_idle("bad_len");
            vectors++;
            if (err !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_len_%h_status: got err %b done %b required 1 0", lens[i], err, done);
            end
            vectors++;
            if (wr_n !== 0 || word_cnt !== 11'd0) begin
                miscompares++;
                $display("FAIL bad_len_%h_writes: got %0d writes cnt %0d required 0 0", lens[i], wr_n, word_cnt);
            end
        end
    endtask

    task automatic test_max_len();
        int bad;
        for (int k = 0; k < 1024; k++) img[k] = {16'(k), ~16'(k)};
        clear_log();
        pulse_start();
        send_len(16'd1024, 0);
        send_body(1024, 0, 32'd0);
        wait_idle("max_len");
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 11'd1024 || wr_n !== 1024) begin
            miscompares++;
            $display("FAIL max_len_status: got done %b err %b cnt %0d writes %0d required 1 0 1024 1024", done, err, word_cnt, wr_n);
        end
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (wr_addr[k] !== 10'(k) || wr_data[k] !== {16'(k), ~16'(k)}) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL max_len_data: got %0d bad words required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        img[0] = 32'hA1A2A3A4;
        img[1] = 32'hB1B2B3B4;
        img[2] = 32'hC1C2C3C4;
        clear_log();
        pulse_start();
        send_len(16'd3, 0);
        send_word(img[0], 0);
        send_byte(8'hB4);
        send_byte(8'hB3);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, cpu_hold, ifc.rx_ready, ifc.mem_we, done, err} !== 6'b0 || word_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_flags: got %b cnt %0d required 000000 0", {busy, cpu_hold, ifc.rx_ready, ifc.mem_we, done, err}, word_cnt);
        end
        vectors++;
        if (ifc.mem_addr !== '0 || ifc.mem_din !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_bus: got addr %h din %h required 0 0", ifc.mem_addr, ifc.mem_din);
        end
        vectors++;
        if (wr_n !== 1) begin
            miscompares++;
            $display("FAIL reset_mid_partial: got %0d writes required 1", wr_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_len(16'd3, 0);
        send_body(3, 0, 32'd0);
        wait_idle("reset_mid");
        vectors++;
        if (wr_n !== 3 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hA1A2A3A4 || wr_addr[2] !== 10'd2 || wr_data[2] !== 32'hC1C2C3C4) begin
            miscompares++;
            $display("FAIL reset_mid_reload: got n %0d %h=%h %h=%h required 3 000=a1a2a3a4 002=c1c2c3c4",
                     wr_n, wr_addr[0], wr_data[0], wr_addr[2], wr_data[2]);
        end
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 11'd3) begin
            miscompares++;
            $display("FAIL reset_mid_status: got done %b err %b cnt %0d required 1 0 3", done, err, word_cnt);
        end
    endtask

    task automatic test_start_busy();
        img[0] = 32'hAABBCCDD;
        img[1] = 32'h11223344;
        clear_log();
        pulse_start();
        send_len(16'd2, 0);
        send_byte(8'hDD);
        pulse_start();
        send_byte(8'hCC);
        send_byte(8'hBB);
        send_byte(8'hAA);
        send_word(img[1], 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(img[0] + img[1], 0);
`endif
        wait_idle("start_busy");
        vectors++;
        if (wr_n !== 2 || wr_data[0] !== 32'hAABBCCDD || wr_data[1] !== 32'h11223344) begin
            miscompares++;
            $display("FAIL start_busy_writes: got n %0d %h %h required 2 aabbccdd 11223344", wr_n, wr_data[0], wr_data[1]);
        end
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 11'd2) begin
            miscompares++;
            $display("FAIL start_busy_status: got done %b err %b cnt %0d required 1 0 2", done, err, word_cnt);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        img[0] = 32'd1;
        img[1] = 32'd2;
        clear_log();
        pulse_start();
        send_len(16'd2, 0);
        send_body(2, 0, 32'd0);
        wait_idle("chk_good");
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_good_status: got done %b err %b required 1 0", done, err);
        end
        clear_log();
        pulse_start();
        send_len(16'd2, 0);
        send_body(2, 0, 32'd1);
        wait_idle("chk_bad");
        vectors++;
        if (done !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL chk_bad_status: got done %b err %b required 0 1", done, err);
        end
        vectors++;
        if (wr_n !== 2 || wr_data[0] !== 32'd1 || wr_data[1] !== 32'd2) begin
            miscompares++;
            $display("FAIL chk_bad_writes: got n %0d %h %h required 2 00000001 00000002", wr_n, wr_data[0], wr_data[1]);
        end
    endtask
`endif

    initial begin
        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_bad_len();
        test_max_len();
        test_reset_mid();
        test_start_busy();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
